// File: rtl/median_pkg.sv
// Shared types and constants for the median filter controller.
package median_pkg;

  localparam int PIX_W     = 8;
  localparam int DEF_WIDTH = 1080;
  localparam int DEF_DEPTH = 1080;
  localparam int CNT_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PROCESS = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] frame_size(input int width, input int depth);
    return CNT_W'(width * depth);
  endfunction

endpackage

// File: rtl/median_filter_ctrl_if.sv
// Pixel stream and filter-core signal bundle for median_filter_ctrl.
// slave: controller side; master: upstream/downstream/filter environment side.
interface median_filter_ctrl_if;
  import median_pkg::*;

  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             flt_rst;
  logic             flt_enable;
  logic             flt_enable_process;
  logic [PIX_W-1:0] flt_pixel_in;
  logic [PIX_W-1:0] flt_pixel_out;

  modport slave (
    input  in_pixel, in_valid, out_ready, flt_pixel_out,
    output in_ready, out_pixel, out_valid, out_last,
           flt_rst, flt_enable, flt_enable_process, flt_pixel_in
  );

  modport master (
    output in_pixel, in_valid, out_ready, flt_pixel_out,
    input  in_ready, out_pixel, out_valid, out_last,
           flt_rst, flt_enable, flt_enable_process, flt_pixel_in
  );

endinterface

// File: rtl/median_out_slot.sv
// One-entry output register: captures the filter result, holds it under
// back-pressure and carries the end-of-frame marker alongside the data.
module median_out_slot
  import median_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [PIX_W-1:0] cap_pixel,
  input  logic             cap_last,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  output logic             out_last
);

  logic [PIX_W-1:0] pixel_r;
  logic             valid_r;
  logic             last_r;

  // Slot register: load on capture, drop on accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_r <= {PIX_W{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (capture) begin
      pixel_r <= cap_pixel;
      valid_r <= 1'b1;
      last_r  <= cap_last;
    end else if (valid_r && out_ready) begin
      pixel_r <= pixel_r;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      pixel_r <= pixel_r;
      valid_r <= valid_r;
      last_r  <= last_r;
    end
  end

  assign out_pixel = pixel_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;

endmodule

// File: rtl/median_filter_ctrl.sv
// Frame controller for a streaming median filter core: clear, load N pixels,
// step the core N times into a 1-entry output slot. Optional frame_count
// output is enabled with MEDIAN_CTRL_FRAME_CNT_EN.
module median_filter_ctrl
  import median_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef MEDIAN_CTRL_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  median_filter_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FRAME_N  = frame_size(WIDTH, DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = FRAME_N - CNT_ONE;

  state_t           state_r;
  logic [CNT_W-1:0] load_cnt_r;
  logic [CNT_W-1:0] issue_cnt_r;
  logic             pending_r;
  logic             pend_last_r;
  logic             busy_r;
  logic             done_r;
  logic             in_ready_r;
  logic             flt_rst_r;

  logic             load_fire_s;
  logic             issue_s;
  logic             last_accept_s;
  logic [PIX_W-1:0] slot_pixel_s;
  logic             slot_valid_s;
  logic             slot_last_s;

  // Handshake decode: pixel accept, filter step issue, final output accept.
  always_comb begin
    load_fire_s   = 1'b0;
    issue_s       = 1'b0;
    last_accept_s = 1'b0;
    if (in_ready_r && bus.in_valid) begin
      load_fire_s = 1'b1;
    end else begin
      load_fire_s = 1'b0;
    end
    // A new step may only start once the slot is free or being drained.
    if ((state_r == ST_PROCESS) && !pending_r &&
        (!slot_valid_s || bus.out_ready) && (issue_cnt_r < FRAME_N)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if ((state_r == ST_PROCESS) && slot_valid_s && bus.out_ready && slot_last_s) begin
      last_accept_s = 1'b1;
    end else begin
      last_accept_s = 1'b0;
    end
  end

  // Main FSM with its registered status outputs and frame counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      load_cnt_r  <= {CNT_W{1'b0}};
      issue_cnt_r <= {CNT_W{1'b0}};
      pending_r   <= 1'b0;
      pend_last_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      flt_rst_r   <= 1'b1;
    end else begin
      done_r    <= 1'b0;
      flt_rst_r <= 1'b0;
      if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + CNT_ONE;
        pending_r   <= 1'b1;
        pend_last_r <= (issue_cnt_r == LAST_IDX);
      end else begin
        pending_r   <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_CLEAR;
            busy_r      <= 1'b1;
            flt_rst_r   <= 1'b1;
            load_cnt_r  <= {CNT_W{1'b0}};
            issue_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          state_r    <= ST_LOAD;
          in_ready_r <= 1'b1;
        end
        ST_LOAD: begin
          if (load_fire_s && (load_cnt_r == LAST_IDX)) begin
            state_r    <= ST_PROCESS;
            in_ready_r <= 1'b0;
            load_cnt_r <= {CNT_W{1'b0}};
          end else if (load_fire_s) begin
            load_cnt_r <= load_cnt_r + CNT_ONE;
          end else begin
            load_cnt_r <= load_cnt_r;
          end
        end
        ST_PROCESS: begin
          if (last_accept_s) begin
            state_r <= ST_FINISH;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_PROCESS;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // The core presents its result the cycle after a step, so capture then.
  median_out_slot u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .capture   (pending_r),
    .cap_pixel (bus.flt_pixel_out),
    .cap_last  (pend_last_r),
    .out_ready (bus.out_ready),
    .out_pixel (slot_pixel_s),
    .out_valid (slot_valid_s),
    .out_last  (slot_last_s)
  );

  assign busy                   = busy_r;
  assign done                   = done_r;
  assign bus.in_ready           = in_ready_r;
  assign bus.flt_rst            = flt_rst_r;
  assign bus.flt_enable         = load_fire_s;
  assign bus.flt_enable_process = issue_s;
  assign bus.flt_pixel_in       = bus.in_pixel;
  assign bus.out_pixel          = slot_pixel_s;
  assign bus.out_valid          = slot_valid_s;
  assign bus.out_last           = slot_last_s;

`ifdef MEDIAN_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_r <= 16'd0;
    end else if (done_r) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_count = frame_cnt_r;
`endif

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Directed bench for median_filter_ctrl on a 3x3 frame with a behavioural
// zero-padded 3x3 median core attached to the filter port.
module tb_median_filter_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
`ifdef MEDIAN_CTRL_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  median_filter_ctrl_if bus();

  median_filter_ctrl #(.WIDTH(3), .DEPTH(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
`ifdef MEDIAN_CTRL_FRAME_CNT_EN
    .frame_count (frame_count),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural filter core: loads pixels, answers each step one cycle later.
  logic [7:0] img [9];
  int ld_idx = 0;
  int pr_idx = 0;

  function automatic logic [7:0] med(input int idx);
    logic [7:0] w [9];
    logic [7:0] t;
    int r, c, n;
    r = idx / 3;
    c = idx % 3;
    n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((r + dr >= 0) && (r + dr < 3) && (c + dc >= 0) && (c + dc < 3))
          w[n] = img[(r + dr) * 3 + c + dc];
        else
          w[n] = 8'd0;
        n++;
      end
    end
    for (int a = 0; a < 9; a++) begin
      for (int b = 0; b < 8 - a; b++) begin
        if (w[b] > w[b+1]) begin
          t = w[b]; w[b] = w[b+1]; w[b+1] = t;
        end
      end
    end
    return w[4];
  endfunction

  always @(posedge clk) begin
    if (bus.flt_rst === 1'b1) begin
      ld_idx            <= 0;
      pr_idx            <= 0;
      bus.flt_pixel_out <= 8'd0;
    end else begin
      if (bus.flt_enable === 1'b1 && ld_idx < 9) begin
        img[ld_idx] <= bus.flt_pixel_in;
        ld_idx      <= ld_idx + 1;
      end
      if (bus.flt_enable_process === 1'b1 && pr_idx < 9) begin
        bus.flt_pixel_out <= med(pr_idx);
        pr_idx            <= pr_idx + 1;
      end
    end
  end

  // Event monitor: strobe counts and accepted outputs with cycle stamps.
  int cyc = 0;
  int en_cnt = 0, pr_cnt = 0, frst_cnt = 0, done_cnt = 0, done_cyc = -1;
  int overlap_cnt = 0, last_err = 0;
  logic [7:0] acc_pix [$];
  logic       acc_last [$];
  int         acc_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst === 1'b1) begin
      if (bus.flt_enable === 1'b1) en_cnt <= en_cnt + 1;
      if (bus.flt_enable_process === 1'b1) pr_cnt <= pr_cnt + 1;
      if (bus.flt_rst === 1'b1) frst_cnt <= frst_cnt + 1;
      if (bus.flt_enable === 1'b1 && bus.flt_enable_process === 1'b1) overlap_cnt <= overlap_cnt + 1;
      if (bus.out_last === 1'b1 && bus.out_valid !== 1'b1) last_err <= last_err + 1;
      if (done === 1'b1) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        acc_pix.push_back(bus.out_pixel);
        acc_last.push_back(bus.out_last);
        acc_cyc.push_back(cyc);
      end
    end
  end

  logic [7:0] img50 [9], img_ramp [9], img100 [9];
  logic [7:0] exp50 [9], exp_ramp [9], exp100 [9];
  int fc_base = 0;

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] pix [9], input int cnt, input int glitch_at);
    int k = 0;
    int guard = 0;
    logic acc;
    while (k < cnt && guard < 60) begin
      bus.in_valid = 1'b1;
      bus.in_pixel = pix[k];
      start = (k == glitch_at) ? 1'b1 : 1'b0;
      acc = bus.in_ready;
      @(negedge clk);
      guard++;
      if (acc === 1'b1) k++;
    end
    start = 1'b0;
    total++;
    if (k != cnt) begin
      $display("FAIL feed_accepts: got=%0d want=%0d", k, cnt);
      bad++;
    end
  endtask

  task automatic wait_done(input int d0, input string name);
    int guard = 0;
    while (done_cnt == d0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (done_cnt != d0 + 1) begin
      $display("FAIL %s_done_pulses: got=%0d want=%0d", name, done_cnt - d0, 1);
      bad++;
    end
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL %s_busy_after: got=%b want=0", name, busy);
      bad++;
    end
  endtask

  task automatic check_frame(input int base, input logic [7:0] exp [9], input string name,
                             input bit spacing);
    total++;
    if (acc_pix.size() - base != 9) begin
      $display("FAIL %s_out_count: got=%0d want=9", name, acc_pix.size() - base);
      bad++;
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (acc_pix[base+i] !== exp[i]) begin
          $display("FAIL %s_pix%0d: got=%0d want=%0d", name, i, acc_pix[base+i], exp[i]);
          bad++;
        end
        total++;
        if (acc_last[base+i] !== ((i == 8) ? 1'b1 : 1'b0)) begin
          $display("FAIL %s_last%0d: got=%b want=%b", name, i, acc_last[base+i], (i == 8));
          bad++;
        end
        if (spacing && i > 0) begin
          total++;
          if (acc_cyc[base+i] - acc_cyc[base+i-1] != 2) begin
            $display("FAIL %s_gap%0d: got=%0d want=2", name, i, acc_cyc[base+i] - acc_cyc[base+i-1]);
            bad++;
          end
        end
      end
      total++;
      if (done_cyc != acc_cyc[base+8] + 1) begin
        $display("FAIL %s_done_timing: got=%0d want=%0d", name, done_cyc, acc_cyc[base+8] + 1);
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_pixel = 8'd0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got=%b want=0", busy); bad++; end
    total++; if (done !== 1'b0) begin $display("FAIL rst_done: got=%b want=0", done); bad++; end
    total++; if (bus.in_ready !== 1'b0) begin $display("FAIL rst_in_ready: got=%b want=0", bus.in_ready); bad++; end
    total++; if (bus.out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got=%b want=0", bus.out_valid); bad++; end
    total++; if (bus.out_last !== 1'b0) begin $display("FAIL rst_out_last: got=%b want=0", bus.out_last); bad++; end
    total++; if (bus.out_pixel !== 8'd0) begin $display("FAIL rst_out_pixel: got=%0d want=0", bus.out_pixel); bad++; end
    total++; if (bus.flt_rst !== 1'b1) begin $display("FAIL rst_flt_rst: got=%b want=1", bus.flt_rst); bad++; end
    total++; if (bus.flt_enable !== 1'b0 || bus.flt_enable_process !== 1'b0) begin
      $display("FAIL rst_strobes: got=%b%b want=00", bus.flt_enable, bus.flt_enable_process); bad++;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_load();
    int e0 = en_cnt;
    int f0 = frst_cnt;
    start_pulse();
    feed(img50, 9, -1);
    total++; if (bus.in_ready !== 1'b0) begin $display("FAIL load_in_ready_after: got=%b want=0", bus.in_ready); bad++; end
    total++; if (frst_cnt - f0 != 1) begin $display("FAIL load_flt_rst_cycles: got=%0d want=1", frst_cnt - f0); bad++; end
    total++; if (busy !== 1'b1) begin $display("FAIL load_busy: got=%b want=1", busy); bad++; end
    @(negedge clk);
    total++; if (en_cnt - e0 != 9) begin $display("FAIL load_enable_pulses: got=%0d want=9", en_cnt - e0); bad++; end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_stream(input int base, input int d0);
    wait_done(d0, "stream50");
    check_frame(base, exp50, "stream50", 1'b1);
  endtask

  task automatic test_stall();
    int base = acc_pix.size();
    int d0 = done_cnt;
    int p0;
    int guard = 0;
    bus.out_ready = 1'b0;
    start_pulse();
    feed(img_ramp, 9, -1);
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    p0 = pr_cnt;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pixel !== 8'd0 || bus.out_last !== 1'b0) begin
        $display("FAIL stall1_hold%0d: got=v%b p%0d l%b want=v1 p0 l0", i, bus.out_valid, bus.out_pixel, bus.out_last);
        bad++;
      end
      @(negedge clk);
    end
    total++; if (pr_cnt != p0) begin $display("FAIL stall1_no_step: got=%0d want=0", pr_cnt - p0); bad++; end
    bus.out_ready = 1'b1;
    guard = 0;
    while ((acc_pix.size() - base) < 4 && guard < 100) begin @(negedge clk); guard++; end
    bus.out_ready = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    p0 = pr_cnt;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pixel !== 8'd5) begin
        $display("FAIL stall2_hold%0d: got=v%b p%0d want=v1 p5", i, bus.out_valid, bus.out_pixel);
        bad++;
      end
      @(negedge clk);
    end
    total++; if (pr_cnt != p0) begin $display("FAIL stall2_no_step: got=%0d want=0", pr_cnt - p0); bad++; end
    bus.out_ready = 1'b1;
    wait_done(d0, "stall");
    check_frame(base, exp_ramp, "stall", 1'b0);
  endtask

  task automatic test_mid_reset();
    int d0 = done_cnt;
    int e0;
    int base;
    bus.out_ready = 1'b1;
    start_pulse();
    feed(img_ramp, 4, -1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin $display("FAIL midrst_busy: got=%b want=0", busy); bad++; end
    total++; if (bus.in_ready !== 1'b0) begin $display("FAIL midrst_in_ready: got=%b want=0", bus.in_ready); bad++; end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (done_cnt != d0) begin $display("FAIL midrst_no_done: got=%0d want=0", done_cnt - d0); bad++; end
    fc_base = done_cnt;
    e0 = en_cnt;
    base = acc_pix.size();
    start_pulse();
    feed(img100, 9, -1);
    bus.in_valid = 1'b0;
    total++; if (en_cnt - e0 != 9) begin $display("FAIL midrst_reload: got=%0d want=9", en_cnt - e0); bad++; end
    wait_done(d0, "midrst");
    check_frame(base, exp100, "midrst", 1'b1);
  endtask

  task automatic test_ignore();
    int e0 = en_cnt;
    int f0;
    int d0 = done_cnt;
    int base = acc_pix.size();
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'hAA;
    repeat (4) @(negedge clk);
    total++; if (en_cnt != e0) begin $display("FAIL ign_idle_accepts: got=%0d want=0", en_cnt - e0); bad++; end
    total++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      $display("FAIL ign_idle_state: got=busy%b rdy%b want=busy0 rdy0", busy, bus.in_ready); bad++;
    end
    bus.in_valid = 1'b0;
    f0 = frst_cnt;
    e0 = en_cnt;
    start_pulse();
    feed(img_ramp, 9, 3);
    bus.in_valid = 1'b0;
    total++; if (en_cnt - e0 != 9) begin $display("FAIL ign_load_count: got=%0d want=9", en_cnt - e0); bad++; end
    total++; if (frst_cnt - f0 != 1) begin $display("FAIL ign_flt_rst: got=%0d want=1", frst_cnt - f0); bad++; end
    wait_done(d0, "ignore");
    check_frame(base, exp_ramp, "ignore", 1'b1);
  endtask

  initial begin
    img50    = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50};
    exp50    = '{8'd0, 8'd50, 8'd0, 8'd50, 8'd50, 8'd50, 8'd0, 8'd50, 8'd0};
    img_ramp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    exp_ramp = '{8'd0, 8'd2, 8'd0, 8'd2, 8'd5, 8'd3, 8'd0, 8'd5, 8'd0};
    img100   = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    exp100   = '{8'd0, 8'd100, 8'd0, 8'd100, 8'd100, 8'd100, 8'd0, 8'd100, 8'd0};

    test_reset();
    test_load();
    test_stream(0, 0);
    test_stall();
    test_mid_reset();
    test_ignore();

    total++; if (overlap_cnt != 0) begin $display("FAIL strobe_overlap: got=%0d want=0", overlap_cnt); bad++; end
    total++; if (last_err != 0) begin $display("FAIL last_without_valid: got=%0d want=0", last_err); bad++; end
`ifdef MEDIAN_CTRL_FRAME_CNT_EN
    total++;
    if (frame_count !== 16'(done_cnt - fc_base)) begin
      $display("FAIL frame_count: got=%0d want=%0d", frame_count, done_cnt - fc_base); bad++;
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median_filter_ctrl.md
MEDIAN_FILTER_CTRL -- requirements
Module: median_filter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1080, meaning image columns.
REQ-002 SHALL have parameter DEPTH, default 1080, meaning image rows; frame size N = WIDTH*DEPTH, with N in 32 bits.
REQ-003 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  frame start pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle end-of-frame pulse.
- in_pixel  in  8  input pixel.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted.
- out_pixel  out  8  filtered pixel.
- out_valid  out  1  filtered pixel valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks pixel N-1.
- flt_rst  out  1  active-high reset to filter.
- flt_enable  out  1  filter load strobe.
- flt_enable_process  out  1  filter process strobe.
- flt_pixel_in  out  8  filter input.
- flt_pixel_out  in  8  filter output.

Function
REQ-004 SHALL implement FSM IDLE, CLEAR, LOAD, PROCESS, FINISH.
REQ-005 In IDLE, start=1 SHALL move the FSM to CLEAR; start SHALL be ignored in every other state.
REQ-006 CLEAR SHALL last exactly one cycle with flt_rst=1, then move to LOAD.
REQ-007 In LOAD, in_ready SHALL be 1.
- Each cycle with in_valid&&in_ready SHALL assert flt_enable, drive flt_pixel_in=in_pixel combinationally, and increment the 32-bit load counter.
- After the Nth accept, the FSM SHALL enter PROCESS and in_ready SHALL be 0 from the next cycle.
REQ-008 Outside LOAD, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-009 flt_enable and flt_enable_process SHALL never be high in the same cycle.
REQ-010 In PROCESS, a step SHALL be issued (flt_enable_process=1 for one cycle) only when all of the following hold:
- no step is pending;
- (!out_valid || out_ready);
- the issue count is < N.
REQ-011 For a step issued in cycle t:
- flt_pixel_out SHALL be captured into out_pixel at the end of cycle t+1;
- out_valid SHALL be 1 from cycle t+2;
- maximum throughput is one pixel per 2 cycles.
REQ-012 out_pixel and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-013 out_last SHALL equal out_valid for the Nth output and SHALL be 0 otherwise.
REQ-014 When the Nth output is accepted, the FSM SHALL enter FINISH, pulse done for one cycle, then return to IDLE.

Reset
REQ-015 While rst=0, the FSM SHALL go to IDLE and clear all counters and the pending flag.
REQ-016 Reset values SHALL be:
- busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_pixel=0;
- flt_enable=0, flt_enable_process=0;
- flt_rst=1 while rst=0.
REQ-017 Reset mid-frame SHALL abandon the frame with no done pulse; the next start SHALL reload all N pixels.

Configuration
REQ-018 With macro MEDIAN_CTRL_FRAME_CNT_EN defined, the block SHALL add output frame_count[15:0]:
- reset to 0;
- increments on each done pulse;
- wraps 0xFFFF to 0.
Without the macro, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-019 Shared package median_pkg SHALL hold:
- the FSM state enum;
- PIX_W=8;
- the default WIDTH and DEPTH;
- the 32-bit counter width constant.
REQ-020 The 1-entry output register (capture, hold, out_last) SHALL be sub-module median_out_slot.

Verification (WIDTH=DEPTH=3, N=9)
REQ-021 rst=0 for 2 cycles -> busy=0, in_ready=0, out_valid=0, done=0, flt_rst=1; no strobes.
REQ-022 Start, then 9 pixels with in_valid held high -> one flt_rst cycle before the first accept; exactly 9 flt_enable pulses; in_ready=0 after the 9th accept.
REQ-023 All-50 image, out_ready=1 -> outputs in raster order, 2 cycles apart, with these values:
- corners 0;
- edges 50;
- centre 50;
- out_last on the 9th output;
- done one cycle after the 9th output is accepted.
REQ-024 out_ready=0 for 5 cycles at the first output -> out_pixel holds; no flt_enable_process during the stall; output resumes on release.
REQ-025 rst=0 after 4 loaded pixels -> IDLE, no done pulse; the next start accepts 9 fresh pixels.
REQ-026 start during LOAD and in_valid during IDLE -> ignored; load count unchanged.
